soc_periph_evt_tx: RTL and testbench

- SoC-side transmitter for the cluster's SoC peripheral event channel: the valid/ready/data interface that the cluster event unit receives.
- Captures single-cycle event pulses from up to NB_EVT_SRC SoC peripheral sources into per-source pending bits.
- Selects pending sources round-robin, queues their IDs in a small FIFO, and presents one ID per handshake.
- Sits in the SoC event fabric next to the cluster boundary and drives the cluster's soc_periph_evt_* inputs.

---
 rtl/soc_periph_evt_tx.sv | 147 ++++++++++++++
 tb/tb_soc_periph_evt_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_periph_evt_tx.sv
// Purpose: latches SoC peripheral event pulses, picks pending sources round-robin, queues their IDs for the cluster event unit.
// Latency: evt_i in cycle 0 -> pending at edge 1 -> ID pushed at edge 2 -> valid_o in cycle 2; sustains one ID per cycle.
// Backpressure: ready_i low holds the FIFO head stable; a full FIFO stalls the arbiter and repeat events on a pending source count as lost.
module soc_periph_evt_tx #(
  parameter int NB_EVT_SRC = 32,
  parameter int EVNT_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_EVT_SRC-1:0] evt_i,
  output logic                  soc_periph_evt_valid_o,
  input  logic                  soc_periph_evt_ready_i,
  output logic [EVNT_WIDTH-1:0] soc_periph_evt_data_o,
  output logic [NB_EVT_SRC-1:0] pending_o,
  output logic [CNT_WIDTH-1:0]  lost_cnt_o,
  input  logic                  lost_cnt_clr_i,
  output logic                  busy_o
);

  localparam int IDX_W = (NB_EVT_SRC > 1) ? $clog2(NB_EVT_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int POP_W = $clog2(NB_EVT_SRC + 1);
  localparam int SUM_W = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;

  // Source IDs must fit on the channel, and pointer wrap relies on a power-of-two depth.
  generate
    if (NB_EVT_SRC > (2 ** EVNT_WIDTH)) begin : g_bad_width
      $error("NB_EVT_SRC does not fit in EVNT_WIDTH");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [NB_EVT_SRC-1:0] pending_q;
  logic [NB_EVT_SRC-1:0] grant;
  logic [NB_EVT_SRC-1:0] lost;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W:0]        scan_idx;
  logic                  win_vld;
  logic                  push_ok;
  logic                  pop;

  logic [EVNT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        count_q;

  logic [POP_W-1:0]      lost_pop;
  logic [CNT_WIDTH-1:0]  lost_base;
  logic [SUM_W-1:0]      lost_sum;
  logic [CNT_WIDTH-1:0]  lost_cnt_d;
  logic [CNT_WIDTH-1:0]  lost_cnt_q;

  // Fullness looks only at the registered count, so a same-cycle pop never opens a slot.
  assign push_ok = (count_q < (PTR_W + 1)'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && soc_periph_evt_ready_i;

  // Round-robin pick: first pending source at or after rr_ptr, wrapping at NB_EVT_SRC.
  always_comb begin
    win_vld  = 1'b0;
    winner   = '0;
    scan_idx = '0;
    grant    = '0;
    if (push_ok) begin
      for (int k = 0; k < NB_EVT_SRC; k++) begin
        scan_idx = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
        if (scan_idx >= (IDX_W + 1)'(NB_EVT_SRC)) begin
          scan_idx = scan_idx - (IDX_W + 1)'(NB_EVT_SRC);
        end
        if (!win_vld && pending_q[scan_idx[IDX_W-1:0]]) begin
          win_vld = 1'b1;
          winner  = scan_idx[IDX_W-1:0];
        end
      end
    end
    if (win_vld) begin
      grant[winner] = 1'b1;
    end
  end

  // Lost events: a new pulse on a source that is still pending and not being granted this cycle.
  always_comb begin
    lost      = evt_i & pending_q & ~grant;
    lost_pop  = '0;
    for (int k = 0; k < NB_EVT_SRC; k++) begin
      lost_pop = lost_pop + POP_W'(lost[k]);
    end
    lost_base = lost_cnt_clr_i ? '0 : lost_cnt_q;
    lost_sum  = SUM_W'(lost_base) + SUM_W'(lost_pop);
    if (lost_sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
      lost_cnt_d = '1;
    end else begin
      lost_cnt_d = lost_sum[CNT_WIDTH-1:0];
    end
  end

  // Pending bits, rotating pointer and lost counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      lost_cnt_q <= '0;
    end else begin
      pending_q  <= (pending_q & ~grant) | evt_i;
      lost_cnt_q <= lost_cnt_d;
      if (win_vld) begin
        rr_ptr_q <= (winner == IDX_W'(NB_EVT_SRC - 1)) ? '0 : winner + IDX_W'(1);
      end
    end
  end

  // ID FIFO; storage is cleared too so data_o reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (win_vld) begin
        mem_q[wr_ptr_q] <= EVNT_WIDTH'(winner);
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (win_vld && !pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (!win_vld && pop) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

  assign soc_periph_evt_valid_o = (count_q != '0);
  assign soc_periph_evt_data_o  = mem_q[rd_ptr_q];
  assign pending_o              = pending_q;
  assign lost_cnt_o             = lost_cnt_q;
  assign busy_o                 = (|pending_q) | (count_q != '0);

endmodule

// File: tb/tb_soc_periph_evt_tx.sv
module tb_soc_periph_evt_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] evt;
  logic        rdy;
  logic        clr;
  logic        valid;
  logic [7:0]  data;
  logic [31:0] pend;
  logic [15:0] lost;
  logic        busy;

  logic [31:0] evt_s;
  logic        rdy_s;
  logic        clr_s;
  logic        valid_s;
  logic [7:0]  data_s;
  logic [31:0] pend_s;
  logic [3:0]  lost_s;
  logic        busy_s;

  int n_chk  = 0;
  int n_fail = 0;
  int got_q[$];
  int got_i[$];

  always #5 clk = ~clk;

  soc_periph_evt_tx dut (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt),
    .soc_periph_evt_valid_o(valid), .soc_periph_evt_ready_i(rdy),
    .soc_periph_evt_data_o(data), .pending_o(pend), .lost_cnt_o(lost),
    .lost_cnt_clr_i(clr), .busy_o(busy)
  );

  soc_periph_evt_tx #(.CNT_WIDTH(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt_s),
    .soc_periph_evt_valid_o(valid_s), .soc_periph_evt_ready_i(rdy_s),
    .soc_periph_evt_data_o(data_s), .pending_o(pend_s), .lost_cnt_o(lost_s),
    .lost_cnt_clr_i(clr_s), .busy_o(busy_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller 1 time unit into cycle 0 with reset released.
  task automatic do_reset();
    rst_n = 1'b0; evt = '0; rdy = 1'b0; clr = 1'b0;
    evt_s = '0; rdy_s = 1'b0; clr_s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Records every accepted ID and the cycle offset it was accepted in.
  task automatic collect(input int ncyc);
    got_q.delete();
    got_i.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (valid === 1'b1 && rdy === 1'b1) begin
        got_q.push_back(int'(data));
        got_i.push_back(i);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt = '0; rdy = 1'b1; clr = 1'b0;
    evt_s = '0; rdy_s = 1'b1; clr_s = 1'b0;
    #1;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_chk++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
    n_chk++; if (pend !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pend); end
    n_chk++; if (lost !== 16'h0) begin n_fail++; $display("FAIL reset_lost: got %h want 0", lost); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (lost_s !== 4'h0) begin n_fail++; $display("FAIL reset_lost_s: got %h want 0", lost_s); end
  endtask

  task automatic test_single_event();
    do_reset();
    rdy = 1'b1;
    evt = 32'h1 << 5;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_c0_valid: got %b want 0", valid); end
    step();
    evt = '0;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid: got %b want 0", valid); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_c1_busy: got %b want 1", busy); end
    n_chk++; if (pend !== 32'h20) begin n_fail++; $display("FAIL single_c1_pending: got %h want 00000020", pend); end
    step();
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_c2_valid: got %b want 1", valid); end
    n_chk++; if (data !== 8'h05) begin n_fail++; $display("FAIL single_c2_data: got %h want 05", data); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_c2_busy: got %b want 1", busy); end
    step();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_c3_valid: got %b want 0", valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_c3_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_a[3];
    int exp_b[2];
    exp_a = '{0, 3, 7};
    exp_b = '{9, 2};
    do_reset();
    rdy = 1'b1;
    evt = (32'h1 << 0) | (32'h1 << 3) | (32'h1 << 7);
    step();
    evt = '0;
    collect(6);
    n_chk++; if (got_q.size() != 3) begin n_fail++; $display("FAIL rr_a_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] != exp_a[i]) begin n_fail++; $display("FAIL rr_a_id[%0d]: got %0d want %0d", i, got_q[i], exp_a[i]); end
      n_chk++; if (got_i[i] != i + 1) begin n_fail++; $display("FAIL rr_a_cycle[%0d]: got %0d want %0d", i, got_i[i], i + 1); end
    end
    evt = (32'h1 << 2) | (32'h1 << 9);
    step();
    evt = '0;
    collect(6);
    n_chk++; if (got_q.size() != 2) begin n_fail++; $display("FAIL rr_b_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] != exp_b[i]) begin n_fail++; $display("FAIL rr_b_id[%0d]: got %0d want %0d", i, got_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_backpressure();
    int exp_bp[5];
    exp_bp = '{1, 2, 3, 4, 6};
    do_reset();
    rdy = 1'b0;
    evt = 32'h5E;
    step();
    evt = '0;
    step();
    step();
    n_chk++; if (data !== 8'h01 || valid !== 1'b1) begin n_fail++; $display("FAIL bp_c3_head: got v=%b d=%h want v=1 d=01", valid, data); end
    step();
    step();
    n_chk++; if (data !== 8'h01 || valid !== 1'b1) begin n_fail++; $display("FAIL bp_c5_head: got v=%b d=%h want v=1 d=01", valid, data); end
    n_chk++; if (pend !== 32'h40) begin n_fail++; $display("FAIL bp_c5_pending: got %h want 00000040", pend); end
    n_chk++; if (lost !== 16'd0) begin n_fail++; $display("FAIL bp_c5_lost: got %0d want 0", lost); end
    evt = 32'h40;
    step();
    evt = '0;
    n_chk++; if (lost !== 16'd1) begin n_fail++; $display("FAIL bp_c6_lost: got %0d want 1", lost); end
    n_chk++; if (data !== 8'h01) begin n_fail++; $display("FAIL bp_c6_data: got %h want 01", data); end
    rdy = 1'b1;
    collect(8);
    n_chk++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] != exp_bp[i]) begin n_fail++; $display("FAIL bp_drain_id[%0d]: got %0d want %0d", i, got_q[i], exp_bp[i]); end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_reevent();
    do_reset();
    rdy = 1'b1;
    evt = 32'h10;
    step();
    step();
    evt = '0;
    collect(6);
    n_chk++; if (got_q.size() != 2) begin n_fail++; $display("FAIL reevt_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] != 4) begin n_fail++; $display("FAIL reevt_id[%0d]: got %0d want 4", i, got_q[i]); end
    end
    n_chk++; if (lost !== 16'd0) begin n_fail++; $display("FAIL reevt_lost: got %0d want 0", lost); end
  endtask

  task automatic test_lost_clear();
    do_reset();
    rdy = 1'b0;
    evt = 32'h7E;
    step();
    evt = '0;
    for (int i = 0; i < 4; i++) step();
    n_chk++; if (pend !== 32'h60) begin n_fail++; $display("FAIL clr_c5_pending: got %h want 00000060", pend); end
    evt = 32'h60;
    step();
    n_chk++; if (lost !== 16'd2) begin n_fail++; $display("FAIL clr_c6_lost: got %0d want 2", lost); end
    clr = 1'b1;
    step();
    evt = '0;
    n_chk++; if (lost !== 16'd2) begin n_fail++; $display("FAIL clr_with_loss: got %0d want 2", lost); end
    step();
    clr = 1'b0;
    n_chk++; if (lost !== 16'd0) begin n_fail++; $display("FAIL clr_alone: got %0d want 0", lost); end
  endtask

  task automatic test_saturation();
    do_reset();
    rdy_s = 1'b0;
    evt_s = 32'h1E;
    step();
    evt_s = '0;
    for (int i = 0; i < 4; i++) step();
    evt_s = 32'h1;
    for (int i = 0; i < 7; i++) step();
    n_chk++; if (lost_s !== 4'd6) begin n_fail++; $display("FAIL sat_mid: got %0d want 6", lost_s); end
    for (int i = 0; i < 13; i++) step();
    evt_s = '0;
    n_chk++; if (lost_s !== 4'd15) begin n_fail++; $display("FAIL sat_end: got %0d want 15", lost_s); end
    n_chk++; if (pend_s !== 32'h1 || data_s !== 8'h01) begin n_fail++; $display("FAIL sat_state: got p=%h d=%h want p=00000001 d=01", pend_s, data_s); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy = 1'b0;
    evt = 32'h0E;
    step();
    evt = 32'h08;
    step();
    evt = '0;
    step();
    step();
    n_chk++; if (valid !== 1'b1 || data !== 8'h01 || lost !== 16'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got v=%b d=%h l=%0d b=%b want v=1 d=01 l=1 b=1", valid, data, lost, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    n_chk++; if (pend !== 32'h0) begin n_fail++; $display("FAIL rstmid_pending: got %h want 0", pend); end
    n_chk++; if (lost !== 16'd0) begin n_fail++; $display("FAIL rstmid_lost: got %0d want 0", lost); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rdy = 1'b1;
    evt = 32'h20;
    step();
    evt = '0;
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_c1_valid: got %b want 0", valid); end
    step();
    n_chk++; if (valid !== 1'b1 || data !== 8'h05) begin n_fail++; $display("FAIL rstmid_c2: got v=%b d=%h want v=1 d=05", valid, data); end
    step();
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_c3_valid: got %b want 0", valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_backpressure();
    test_reevent();
    test_lost_clear();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
